// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction over
// a req/ack handshake, holds it for the decoder and commits the next PC from
// the decoder's jump/jr/branch outcome. Also keeps a retired-instruction count.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             stall,
  input  logic             jump,
  input  logic             jr,
  input  logic             branch_taken,
  input  logic [31:0]      jr_target,
  output logic             addr_err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_addr_err;
  logic [CNT_W-1:0] r_count;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_br_off;
  logic [31:0]      w_next_pc;
  logic             w_fetch_done;
  logic             w_commit;
  logic             w_jr_misaligned;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_br_off        = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_jr_misaligned = jr && (jr_target[1:0] != 2'b00);

  // State register; reset restarts fetching at RESET_PC.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_state_next;
  end

  // Next-state logic and handshake outputs; ack is only honoured in FETCH.
  always_comb begin
    w_state_next = r_state;
    w_fetch_done = 1'b0;
    w_commit     = 1'b0;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_fetch_done = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          w_commit     = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      default: w_state_next = ST_FETCH;
    endcase
  end

  // Next-PC selection, priority jr > jump > branch > sequential.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jr)                w_next_pc = {jr_target[31:2], 2'b00};
    else if (jump)         w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    else if (branch_taken) w_next_pc = w_pc_plus4 + w_br_off;
  end

  // Datapath registers: capture fetched word, commit PC/count/error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0;
      r_addr_err <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_fetch_done) r_instr <= imem_rdata;
      if (w_commit) begin
        r_pc    <= w_next_pc;
        r_count <= r_count + CNT_W'(1);
        if (w_jr_misaligned) r_addr_err <= 1'b1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign addr_err    = r_addr_err;
  assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of one-instruction transactions with
// hand-computed next-PC values, plus sequences for stall, reset and wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall, jump, jr, branch_taken;
  logic [31:0] jr_target;

  logic        imem_req, instr_valid, addr_err;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [31:0] instr_count;

  logic        imem_req_4, instr_valid_4, addr_err_4;
  logic [31:0] imem_addr_4, instr_4, pc_4, pc_plus4_4;
  logic [3:0]  instr_count_4;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [31:0] exp_pc = 32'h0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
    .jump(jump), .jr(jr), .branch_taken(branch_taken), .jr_target(jr_target),
    .addr_err(addr_err), .instr_count(instr_count)
  );

  fetch_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .imem_req(imem_req_4), .imem_addr(imem_addr_4),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr_4),
    .instr_valid(instr_valid_4), .pc(pc_4), .pc_plus4(pc_plus4_4), .stall(stall),
    .jump(jump), .jr(jr), .branch_taken(branch_taken), .jr_target(jr_target),
    .addr_err(addr_err_4), .instr_count(instr_count_4)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        jmp;
    logic        jrr;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One fetch (zero-wait ack) followed by an immediate commit with given controls.
  task automatic do_instr(input logic [31:0] rdata, input logic jmp, input logic jrr,
                          input logic br, input logic [31:0] tgt,
                          input logic [31:0] npc, input logic err);
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    chk("issue_valid", {31'b0, instr_valid}, 32'd1);
    chk("issue_instr", instr, rdata);
    chk("issue_req", {31'b0, imem_req}, 32'd0);
    jump = jmp; jr = jrr; branch_taken = br; jr_target = tgt;
    step();
    jump = 1'b0; jr = 1'b0; branch_taken = 1'b0; jr_target = 32'h0;
    exp_cnt++;
    exp_pc = npc;
    chk("commit_pc", pc, npc);
    chk("commit_cnt", instr_count, exp_cnt);
    chk("commit_cnt4", {28'b0, instr_count_4}, exp_cnt % 16);
    chk("addr_err", {31'b0, addr_err}, {31'b0, err});
    $display("instr %h j=%0b jr=%0b br=%0b tgt=%h -> pc=%h cnt=%0d err=%0b",
             rdata, jmp, jrr, br, tgt, pc, instr_count, addr_err);
  endtask

  initial begin
    //               rdata          j   jr  br  tgt            next pc        err
    vecs[0]  = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0004, 1'b0};
    vecs[1]  = '{32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0010, 1'b0};
    vecs[2]  = '{32'h1000_FFFF, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0000_0010, 1'b0};
    vecs[3]  = '{32'h1000_FFFF, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0014, 1'b0};
    vecs[4]  = '{32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'h4000_0008, 32'h4000_0008, 1'b0};
    vecs[5]  = '{32'h0810_0000, 1'b1, 1'b0, 1'b0, 32'h0,        32'h4040_0000, 1'b0};
    vecs[6]  = '{32'h0810_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0000_0100, 1'b1};
    vecs[7]  = '{32'h1000_FFFF, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0104, 1'b1};
    vecs[8]  = '{32'h1000_0003, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0000_0114, 1'b1};
    vecs[9]  = '{32'h0000_0008, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
    vecs[10] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b1};

    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    jump = 1'b0; jr = 1'b0; branch_taken = 1'b0; jr_target = 32'h0;
    repeat (2) step();
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_err", {31'b0, addr_err}, 32'd0);
    chk("rst_cnt", instr_count, 32'd0);
    chk("rst_pc4", pc_plus4, 32'h4);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      do_instr(vecs[i].rdata, vecs[i].jmp, vecs[i].jrr, vecs[i].br,
               vecs[i].tgt, vecs[i].exp_pc, vecs[i].exp_err);

    // Slow memory (3 idle cycles) then 4 stall cycles in ISSUE.
    for (int k = 0; k < 3; k++) begin
      chk("slow_req", {31'b0, imem_req}, 32'd1);
      chk("slow_valid", {31'b0, instr_valid}, 32'd0);
      step();
    end
    chk("slow_req", {31'b0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
    step();
    imem_ack = 1'b1; imem_rdata = 32'h89AB_CDEF;  // ack in ISSUE must be ignored
    stall = 1'b1; jump = 1'b1;                     // controls ignored while stalled
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'h0123_4567);
      chk("stall_pc", pc, exp_pc);
      chk("stall_cnt", instr_count, exp_cnt);
      step();
    end
    imem_ack = 1'b0; stall = 1'b0; jump = 1'b0;
    chk("unstall_valid", {31'b0, instr_valid}, 32'd1);
    step();
    exp_cnt++;
    exp_pc = exp_pc + 32'd4;
    chk("unstall_pc", pc, exp_pc);
    chk("unstall_cnt", instr_count, exp_cnt);
    chk("unstall_req", {31'b0, imem_req}, 32'd1);
    $display("stalled instr 01234567 -> pc=%h cnt=%0d", pc, instr_count);

    // Reset in FETCH with ack pending: the fetched word is dropped.
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    reset = 1'b0; imem_ack = 1'b0;
    exp_cnt = 0; exp_pc = 32'h0;
    chk("rstf_instr", instr, 32'h0);
    chk("rstf_cnt", instr_count, 32'd0);
    chk("rstf_addr", imem_addr, 32'h0);
    chk("rstf_valid", {31'b0, instr_valid}, 32'd0);
    chk("rstf_err", {31'b0, addr_err}, 32'd0);
    $display("reset in FETCH -> addr=%h instr=%h cnt=%0d", imem_addr, instr, instr_count);

    // Reset in ISSUE: no commit happens, held word discarded.
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    imem_ack = 1'b0;
    chk("rsti_valid", {31'b0, instr_valid}, 32'd1);
    reset = 1'b1; jr = 1'b1; jr_target = 32'h0000_0203;
    step();
    reset = 1'b0; jr = 1'b0; jr_target = 32'h0;
    chk("rsti_cnt", instr_count, 32'd0);
    chk("rsti_instr", instr, 32'h0);
    chk("rsti_pc", pc, 32'h0);
    chk("rsti_err", {31'b0, addr_err}, 32'd0);
    chk("rsti_req", {31'b0, imem_req}, 32'd1);
    $display("reset in ISSUE -> pc=%h cnt=%0d err=%0b", pc, instr_count, addr_err);

    // 16 sequential commits: 4-bit counter wraps to zero.
    for (int k = 0; k < 16; k++)
      do_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, exp_pc + 32'd4, 1'b0);
    chk("wrap_cnt4", {28'b0, instr_count_4}, 32'd0);
    chk("wrap_cnt32", instr_count, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the MIPS core, directly upstream of the main control decoder. It owns the PC, fetches one word per instruction from instruction memory over a req/ack handshake, and holds the fetched word so the decoder and datapath can consume it. It then computes and commits the next PC from the decoder's Jump/Jr/branch outcome. It also supplies PC+4 for the JAL link write and keeps a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock; clears all state
imem_req  output  1  fetch request, high only in FETCH
imem_addr  output  32  byte address of fetch, equals pc
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr  output  32  held instruction; opcode instr[31:26] drives the decoder
instr_valid  output  1  instr is valid and awaiting issue (state ISSUE)
pc  output  32  address of the instruction currently held/fetched
pc_plus4  output  32  pc + 4 (JAL link value, branch base)
stall  input  1  datapath hold; blocks commit in ISSUE
jump  input  1  decoder Jump (J/JAL)
jr  input  1  decoder Jr
branch_taken  input  1  Branch AND (zero for BEQ / !zero for BNE), from datapath
jr_target  input  32  rs value from register file
addr_err  output  1  sticky: a jr_target with nonzero bits [1:0] was committed
instr_count  output  CNT_W  instructions committed since reset

Behaviour:
- Reset (synchronous, dominates every other input): pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, addr_err=0, instr_count=0. imem_req=1 in the first cycle after reset deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, instr<=imem_rdata and go to ISSUE. Otherwise stay, with no timeout.
  - ISSUE: instr_valid=1, imem_req=0. If stall=1, hold everything. If stall=0, pc<=next_pc, instr_count<=instr_count+1 (wraps modulo 2^CNT_W), go to FETCH.
- imem_ack in ISSUE is ignored. Zero-wait memory (ack in the same cycle as req) gives 2 cycles per instruction.
- Control inputs are sampled only in ISSUE with stall=0. They are don't-care elsewhere.
- next_pc priority: jr > jump > branch_taken > sequential.
  - jr: {jr_target[31:2], 2'b00}; if jr_target[1:0] != 0, set addr_err=1 (sticky until reset).
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch_taken: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), 32-bit wrap.
  - else: pc_plus4.
- pc_plus4 = pc + 4, 32-bit wrap (0xFFFF_FFFC -> 0x0000_0000).
- instr and pc are stable for the whole of ISSUE, including any stall cycles.
- Reset during FETCH with a pending ack: the ack is dropped and fetch restarts at RESET_PC. Reset during ISSUE: the held instr is discarded and no count increment occurs.
- Simultaneous jr and jump both set: jr wins.

Test Plan:
- Reset release, imem_ack tied high, imem_rdata=32'h2008_0005 (ADDI): imem_addr=0 in cycle 0, instr_valid=1 in cycle 1, pc=4 in cycle 2, instr_count=1.
- Ack delayed 3 cycles, then stall=1 for 4 ISSUE cycles: imem_req stays high 4 cycles, instr/pc stay constant during stall, and the commit happens exactly on the first stall=0 cycle.
- pc=0x0000_0010, instr=32'h1000_FFFF, branch_taken=1: next pc=0x0000_0010 (0x14 + -4). With branch_taken=0: pc=0x14.
- pc=0x4000_0008, instr=32'h0810_0000, jump=1: next pc=0x4040_0000. Add jr=1 with jr_target=0x0000_0102: pc=0x0000_0100 and addr_err=1, which stays 1 on later commits.
- Reset asserted in FETCH while imem_ack=1: instr stays 0, instr_count stays 0, next imem_addr=RESET_PC. Also check count wrap with CNT_W=4: 16 commits give instr_count=0.
